// File: rtl/relay_sequencer.sv
// relay_sequencer: walks relay outputs toward a target pattern one bit per dwell, with fault override
module relay_sequencer #(
    parameter int N_RELAY      = 8,
    parameter int DWELL_CYCLES = 2000000,
    parameter int CNT_W        = 24
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic [N_RELAY-1:0] target,
    input  logic               target_wr,
    input  logic               fault,
    input  logic               fault_clr,
    output logic [N_RELAY-1:0] relay_out,
    output logic               busy,
    output logic               done,
    output logic               in_fault,
    output logic               rejected
);
    typedef enum logic [1:0] {IDLE, SWITCH, DWELL, FAULT} state_t;
    state_t state, state_nx;
    logic [N_RELAY-1:0] tgt_q, tgt_nx, relay_nx, opens, closes, pick;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic busy_nx, done_nx, in_fault_nx, rejected_nx;
    // next state, next relay pattern and registered-output values; openings win over closings, lowest index first
    always_comb begin
        opens       = relay_out & ~tgt_q;
        closes      = ~relay_out & tgt_q;
        pick        = (opens != '0) ? (opens & -opens) : (closes & -closes);
        state_nx    = state;
        tgt_nx      = tgt_q;
        relay_nx    = relay_out;
        cnt_nx      = cnt;
        if (fault && state != FAULT) begin
            state_nx = FAULT;
            tgt_nx   = '0;
            relay_nx = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (target_wr) begin
                        tgt_nx   = target;
                        state_nx = SWITCH;
                    end
                end
                SWITCH: begin
                    tgt_nx = target_wr ? target : tgt_q;
                    if (pick == '0) begin
                        state_nx = IDLE;
                    end else begin
                        relay_nx = relay_out ^ pick;
                        cnt_nx   = CNT_W'(DWELL_CYCLES - 1);
                        state_nx = DWELL;
                    end
                end
                DWELL: begin
                    tgt_nx   = target_wr ? target : tgt_q;
                    state_nx = (cnt == '0) ? SWITCH : DWELL;
                    cnt_nx   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
                end
                default: begin
                    tgt_nx   = '0;
                    relay_nx = '0;
                    state_nx = (fault_clr && !fault) ? IDLE : FAULT;
                end
            endcase
        end
        busy_nx     = (state == SWITCH || state == DWELL) && (state_nx == SWITCH || state_nx == DWELL);
        done_nx     = (state == SWITCH) && (state_nx == IDLE);
        in_fault_nx = (state_nx == FAULT);
        rejected_nx = (state == FAULT) && target_wr;
    end
    // state and output registers; reset opens every relay without waiting for a clock
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            tgt_q     <= '0;
            relay_out <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_fault  <= 1'b0;
            rejected  <= 1'b0;
        end else begin
            state     <= state_nx;
            tgt_q     <= tgt_nx;
            relay_out <= relay_nx;
            cnt       <= cnt_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            in_fault  <= in_fault_nx;
            rejected  <= rejected_nx;
        end
    end
endmodule

// File: tb/tb_relay_sequencer.sv
// tb_relay_sequencer: randomized and directed checks of relay_sequencer against a schedule-based model
module tb_relay_sequencer;
    localparam int DW   = 4;
    localparam int STEP = DW + 1;
    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic [7:0] target = '0;
    logic       target_wr = 1'b0, fault = 1'b0, fault_clr = 1'b0;
    logic [7:0] relay_out;
    logic       busy, done, in_fault, rejected;
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] cur = '0;
    logic [7:0] seq [0:15];

    relay_sequencer #(.N_RELAY(8), .DWELL_CYCLES(DW), .CNT_W(8)) dut (
        .CLK(CLK), .RESETn(RESETn), .target(target), .target_wr(target_wr),
        .fault(fault), .fault_clr(fault_clr), .relay_out(relay_out),
        .busy(busy), .done(done), .in_fault(in_fault), .rejected(rejected)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic build_seq(input logic [7:0] from, input logic [7:0] to, output int n);
        logic [7:0] p;
        bit hit;
        p = from;
        n = 0;
        seq[0] = from;
        while (p != to) begin
            hit = 0;
            for (int i = 0; i < 8; i++) if (!hit && p[i] && !to[i]) begin p[i] = 1'b0; hit = 1; end
            for (int i = 0; i < 8; i++) if (!hit && !p[i] && to[i]) begin p[i] = 1'b1; hit = 1; end
            n++;
            seq[n] = p;
        end
    endtask

    task automatic write_and_check(input string name, input logic [7:0] t);
        int n, m;
        logic [7:0] prev;
        logic exp_done, exp_busy;
        build_seq(cur, t, n);
        target = t;
        target_wr = 1'b1;
        tick();
        target_wr = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || relay_out !== cur || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s accept: relay=%h busy=%b done=%b, want relay=%h busy=0 done=0", name, relay_out, busy, done, cur);
        end
        prev = relay_out;
        for (int k = 1; k <= 1 + STEP * n; k++) begin
            tick();
            m = (n == 0) ? 0 : (((k - 1) / STEP + 1 > n) ? n : (k - 1) / STEP + 1);
            exp_done = (k == 1 + STEP * n);
            exp_busy = (n > 0) && (k < 1 + STEP * n);
            n_cmp++;
            if (relay_out !== seq[m] || done !== exp_done || busy !== exp_busy) begin
                n_bad++;
                $display("FAIL %s step k=%0d: relay=%h done=%b busy=%b, want relay=%h done=%b busy=%b",
                         name, k, relay_out, done, busy, seq[m], exp_done, exp_busy);
            end
            n_cmp++;
            if ($countones(relay_out ^ prev) > 1) begin
                n_bad++;
                $display("FAIL %s onebit k=%0d: relay=%h prev=%h, want at most one bit changed", name, k, relay_out, prev);
            end
            prev = relay_out;
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || relay_out !== t) begin
            n_bad++;
            $display("FAIL %s settle: relay=%h done=%b busy=%b, want relay=%h done=0 busy=0", name, relay_out, done, busy, t);
        end
        cur = t;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if (relay_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || in_fault !== 1'b0 || rejected !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: relay=%h busy=%b done=%b in_fault=%b rejected=%b, want all 0", relay_out, busy, done, in_fault, rejected);
        end
        RESETn = 1'b1;
        tick();
        n_cmp++;
        if (relay_out !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: relay=%h busy=%b, want 00/0", relay_out, busy);
        end
        cur = 8'h00;
    endtask

    task automatic test_basic_close();
        write_and_check("basic_close", 8'h05);
    endtask

    task automatic test_open_before_close();
        write_and_check("obc_setup", 8'h03);
        write_and_check("open_before_close", 8'h0C);
    endtask

    task automatic test_equal();
        write_and_check("equal_target", cur);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) write_and_check("random", 8'($urandom_range(0, 255)));
    endtask

    task automatic test_retarget();
        write_and_check("retarget_setup", 8'h00);
        target = 8'hFF;
        target_wr = 1'b1;
        tick();
        target_wr = 1'b0;
        tick();
        n_cmp++;
        if (relay_out !== 8'h01 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL retarget_first: relay=%h busy=%b, want 01/1", relay_out, busy);
        end
        tick();
        target = 8'h01;
        target_wr = 1'b1;
        tick();
        target_wr = 1'b0;
        for (int k = 4; k <= 9; k++) begin
            tick();
            n_cmp++;
            if (relay_out !== 8'h01 || done !== (k == 6) || busy !== (k < 6)) begin
                n_bad++;
                $display("FAIL retarget k=%0d: relay=%h done=%b busy=%b, want relay=01 done=%b busy=%b",
                         k, relay_out, done, busy, k == 6, k < 6);
            end
        end
        cur = 8'h01;
    endtask

    task automatic test_fault();
        target = 8'hFF;
        target_wr = 1'b1;
        tick();
        target_wr = 1'b0;
        tick();
        tick();
        fault = 1'b1;
        tick();
        n_cmp++;
        if (relay_out !== 8'h00 || in_fault !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_entry: relay=%h in_fault=%b busy=%b, want 00/1/0", relay_out, in_fault, busy);
        end
        target = 8'hAA;
        target_wr = 1'b1;
        tick();
        target_wr = 1'b0;
        n_cmp++;
        if (rejected !== 1'b1 || relay_out !== 8'h00) begin
            n_bad++;
            $display("FAIL fault_reject: rejected=%b relay=%h, want 1/00", rejected, relay_out);
        end
        tick();
        n_cmp++;
        if (rejected !== 1'b0 || relay_out !== 8'h00) begin
            n_bad++;
            $display("FAIL fault_reject_pulse: rejected=%b relay=%h, want 0/00", rejected, relay_out);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_cmp++;
        if (in_fault !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_clr_ignored: in_fault=%b, want 1", in_fault);
        end
        fault = 1'b0;
        tick();
        n_cmp++;
        if (in_fault !== 1'b1 || relay_out !== 8'h00) begin
            n_bad++;
            $display("FAIL fault_hold: in_fault=%b relay=%h, want 1/00", in_fault, relay_out);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_cmp++;
        if (in_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_exit: in_fault=%b, want 0", in_fault);
        end
        cur = 8'h00;
        write_and_check("after_fault", 8'h81);
    endtask

    task automatic test_fault_and_write();
        fault = 1'b1;
        target = 8'hFF;
        target_wr = 1'b1;
        tick();
        target_wr = 1'b0;
        n_cmp++;
        if (in_fault !== 1'b1 || relay_out !== 8'h00 || busy !== 1'b0 || rejected !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_wr_entry: in_fault=%b relay=%h busy=%b rejected=%b, want 1/00/0/0", in_fault, relay_out, busy, rejected);
        end
        fault = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (relay_out !== 8'h00 || busy !== 1'b0 || in_fault !== 1'b0) begin
                n_bad++;
                $display("FAIL fault_wr_idle k=%0d: relay=%h busy=%b in_fault=%b, want 00/0/0", k, relay_out, busy, in_fault);
            end
        end
        cur = 8'h00;
    endtask

    task automatic test_async_reset();
        target = 8'hFF;
        target_wr = 1'b1;
        tick();
        target_wr = 1'b0;
        tick();
        tick();
        #2;
        RESETn = 1'b0;
        #1;
        n_cmp++;
        if (relay_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || in_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: relay=%h busy=%b done=%b in_fault=%b, want all 0", relay_out, busy, done, in_fault);
        end
        #3;
        RESETn = 1'b1;
        tick();
        n_cmp++;
        if (relay_out !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_release: relay=%h busy=%b, want 00/0", relay_out, busy);
        end
        cur = 8'h00;
        write_and_check("after_reset", 8'h3C);
    endtask

    initial begin
        test_reset();
        test_basic_close();
        test_open_before_close();
        test_equal();
        test_random();
        test_retarget();
        test_fault();
        test_fault_and_write();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/relay_sequencer.md
# relay_sequencer

Sequences the board relay outputs so that at most one relay changes state per dwell interval. This limits coil inrush and contact bounce overlap. The block sits between the DSP-writable relay register and the relay output pins. The register value is the target pattern, and this block walks the outputs toward it one bit at a time. A synchronized fault input forces all relays open immediately and holds them open until software clears the fault.

## Interface
Parameters:
- N_RELAY, 8: number of relay outputs.
- DWELL_CYCLES, 2000000: minimum gap after each relay change, in CLK cycles (10 ms at 200 MHz). Must be ≥ 1.
- CNT_W, 24: dwell counter width. Must satisfy 2^CNT_W > DWELL_CYCLES.

Ports:
- CLK  in  1  system clock (200 MHz domain).
- RESETn  in  1  reset; one clock; reset is asynchronous and active-low.
- target  in  N_RELAY  requested relay pattern (1 = closed).
- target_wr  in  1  one-cycle strobe that latches target.
- fault  in  1  active-high fault, already synchronized to CLK.
- fault_clr  in  1  one-cycle strobe that leaves the FAULT state.
- relay_out  out  N_RELAY  registered relay drive (1 = closed).
- busy  out  1  high while in SWITCH or DWELL.
- done  out  1  one-cycle pulse when relay_out first equals the latched target.
- in_fault  out  1  high while in FAULT.
- rejected  out  1  one-cycle pulse when target_wr arrives during FAULT.

## Operation
- State machine states:
  - IDLE: target_wr latches target into tgt_q and moves to SWITCH.
  - SWITCH: computes diff = tgt_q ^ relay_out.
    - If diff = 0: go to IDLE and pulse done.
    - Otherwise toggle exactly one relay_out bit, load cnt = DWELL_CYCLES-1, and go to DWELL.
  - DWELL: cnt decrements each cycle. When cnt = 0, go to SWITCH.
  - FAULT: relay_out = 0 and tgt_q = 0.
    - fault_clr with fault = 0 moves to IDLE.
    - fault_clr while fault = 1 is ignored.
- Bit selection order:
  - Openings first: the lowest index i with relay_out[i]=1 and tgt_q[i]=0.
  - Then closings: the lowest index i with relay_out[i]=0 and tgt_q[i]=1.
- target_wr in SWITCH or DWELL:
  - tgt_q is overwritten.
  - The current dwell is not shortened.
  - The next SWITCH uses the new tgt_q.
- fault = 1 in any non-FAULT state:
  - At the next edge, relay_out <= 0, tgt_q <= 0, the state goes to FAULT, and the dwell counter is cleared.
  - fault has priority over target_wr in the same cycle.
- target_wr during FAULT is dropped, and rejected pulses.
- Reset values:
  - State IDLE.
  - relay_out = 0, tgt_q = 0, cnt = 0.
  - busy = 0, done = 0, in_fault = 0, rejected = 0.
- Asserting RESETn mid-sequence immediately opens all relays. There is no dwell after release.

## Timing
- All outputs are registered.
- target_wr sampled at edge T:
  - State is SWITCH after edge T.
  - The first relay_out change happens at edge T+1.
  - busy is high from T+1.
- Consecutive relay_out changes are exactly DWELL_CYCLES+1 cycles apart.
- After the final toggle, done pulses DWELL_CYCLES+1 cycles later (end of dwell, then SWITCH sees diff = 0). busy falls in the same cycle.
- target_wr equal to the current relay_out: done pulses at edge T+1 with no toggle.
- fault sampled at edge F: relay_out = 0 and in_fault = 1 after edge F (1-cycle latency).
- fault_clr sampled at edge C with fault = 0: in_fault = 0 after edge C, and new target_wr is accepted from edge C+1.

## Test plan
- Basic close: DWELL_CYCLES=4. Reset, then target=0x05 with target_wr.
  - Expect relay_out 0x01 at T+1 and 0x05 at T+6.
  - Expect done pulse at T+11.
  - Expect busy high T+1..T+10.
- Open before close: from relay_out=0x03, write 0x0C.
  - Expect the sequence 0x02, 0x00, 0x04, 0x0C.
  - Each step 5 cycles apart; never more than one bit changes per step.
- Retarget mid-dwell: from 0x00, write 0xFF, then write 0x01 two cycles after the first toggle.
  - Expect relay_out to stay 0x01.
  - Expect done after that dwell ends, with no second toggle.
- Fault during DWELL: assert fault.
  - Expect relay_out=0 and in_fault=1 one cycle later.
  - target_wr issued next gives a rejected pulse and no change.
  - fault_clr while fault=1 is ignored.
  - After fault drops, fault_clr returns to IDLE, and the next write sequences normally.
- Simultaneous fault and target_wr in IDLE: expect FAULT entered, tgt_q=0, and no relay closes.
- Async reset mid-sequence: drop RESETn between edges.
  - Expect relay_out=0, busy=0, done=0 immediately, without waiting for a CLK edge.
  - After release, the state is IDLE.
